// File: rtl/regfile_cmd_ctrl.sv
// regfile_cmd_ctrl: UART command-side initiator for the system register file.
// Decodes write frames (WR_CMD, addr, data) and read frames (RD_CMD, addr),
// strobes the register file, and returns read data as one byte on a
// valid/ready handshake toward the UART transmitter.
// Optional feature macro: RD_TIMEOUT_EN -- when defined, a read that gets no
// RdData_Valid within TIMEOUT_CYCLES cycles answers with ERR_BYTE instead of
// waiting forever.
module regfile_cmd_ctrl #(
  parameter int unsigned                ADDR_WIDTH     = 4,
  parameter int unsigned                DATA_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0]      WR_CMD         = 8'hAA,
  parameter logic [DATA_WIDTH-1:0]      RD_CMD         = 8'hBB,
  parameter int unsigned                TIMEOUT_CYCLES = 8,
  parameter logic [DATA_WIDTH-1:0]      ERR_BYTE       = 8'hEE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  TX_READY,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  CTRL_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_STRB,
    S_RD_ADDR,
    S_RD_STRB,
    S_RD_WAIT,
    S_TX_SEND
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  busy_q, busy_d;

`ifdef RD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  // Watchdog counts cycles spent in RD_WAIT; it restarts from zero on every entry.
  always_comb begin
    cnt_d       = (state_q == S_RD_WAIT) ? cnt_q + CNT_W'(1) : '0;
    timeout_hit = (state_q == S_RD_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^ERR_BYTE ^ (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and next-output decode; strobes default low so each lasts one cycle.
  always_comb begin
    state_d   = state_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = tx_vld_q;

    case (state_q)
      S_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_d = S_WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_d = S_RD_ADDR;
          end
        end
      end
      S_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = S_WR_STRB;
        end
      end
      S_WR_STRB: begin
        state_d = S_IDLE;
      end
      S_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = S_RD_STRB;
        end
      end
      S_RD_STRB: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // Real data wins over a watchdog expiry in the same cycle.
        if (RdData_Valid) begin
          tx_data_d = RdData;
          tx_vld_d  = 1'b1;
          state_d   = S_TX_SEND;
        end
`ifdef RD_TIMEOUT_EN
        else if (timeout_hit) begin
          tx_data_d = ERR_BYTE;
          tx_vld_d  = 1'b1;
          state_d   = S_TX_SEND;
        end
`endif
      end
      S_TX_SEND: begin
        if (TX_READY) begin
          tx_vld_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef RD_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      busy_q    <= busy_d;
`ifdef RD_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CTRL_BUSY = busy_q;

endmodule
